// File: rtl/lock_cmd_arbiter_pkg.sv
// Types and helpers for the lock command arbiter.
// Command field positions and codes come from OmpSsManager.
package lock_cmd_arbiter_pkg;

  import OmpSsManager::*;

  localparam int unsigned CmdWidth = 64;

  typedef enum logic {
    StEmpty,
    StFull
  } slot_state_e;

  // True for the only command types the lock unit understands.
  function automatic logic is_lock_cmd(input logic [CmdWidth-1:0] word);
    logic [CMD_TYPE_H-CMD_TYPE_L:0] code;
    code = word[CMD_TYPE_H:CMD_TYPE_L];
    return (code == CMD_LOCK_CODE) || (code == CMD_UNLOCK_CODE);
  endfunction

endpackage

// File: rtl/ompss_manager_pkg.sv
// Shared OmpSs manager command word layout and command codes.
// Every block that decodes manager command words takes these values from here.
package OmpSsManager;

  localparam int unsigned CMD_TYPE_L = 0;
  localparam int unsigned CMD_TYPE_H = 7;

  localparam logic [7:0] CMD_LOCK_CODE   = 8'h04;
  localparam logic [7:0] CMD_UNLOCK_CODE = 8'h05;

endpackage

// File: rtl/lock_cmd_arbiter_if.sv
// Accelerator command ports plus the single stream towards the lock unit.
// The arbiter uses the slave modport; command sources and the lock unit drive master.
interface lock_cmd_arbiter_if
  import lock_cmd_arbiter_pkg::*;
#(
  parameter int unsigned MAX_ACCS = 16
);

  localparam int unsigned TidWidth = $clog2(MAX_ACCS);

  logic [CmdWidth*MAX_ACCS-1:0] in_TDATA;
  logic [MAX_ACCS-1:0]          in_TVALID;
  logic [MAX_ACCS-1:0]          in_TREADY;

  logic [CmdWidth-1:0]          outStream_TDATA;
  logic                         outStream_TVALID;
  logic                         outStream_TREADY;
  logic [TidWidth-1:0]          outStream_TID;

  modport master (
    output in_TDATA,
    output in_TVALID,
    input  in_TREADY,
    input  outStream_TDATA,
    input  outStream_TVALID,
    output outStream_TREADY,
    input  outStream_TID
  );

  modport slave (
    input  in_TDATA,
    input  in_TVALID,
    output in_TREADY,
    output outStream_TDATA,
    output outStream_TVALID,
    input  outStream_TREADY,
    output outStream_TID
  );

endinterface

// File: rtl/lock_arb_rr_select.sv
// Round-robin search: first set bit of valid_i at or above rr_ptr_i, wrapping to 0.
// Purely combinational.
module lock_arb_rr_select #(
  parameter int unsigned MAX_ACCS = 16,
  localparam int unsigned IdxWidth = $clog2(MAX_ACCS)
) (
  input  logic [MAX_ACCS-1:0] valid_i,
  input  logic [IdxWidth-1:0] rr_ptr_i,
  output logic                grant_o,
  output logic [IdxWidth-1:0] idx_o
);

  int unsigned pos;

  always_comb begin
    grant_o = 1'b0;
    idx_o   = '0;
    pos     = 0;
    // Scan from the farthest candidate down so the one nearest rr_ptr_i is written last.
    for (int i = MAX_ACCS - 1; i >= 0; i--) begin
      pos = 32'(rr_ptr_i) + 32'(i);
      if (pos >= MAX_ACCS) begin
        pos = pos - MAX_ACCS;
      end
      if (valid_i[IdxWidth'(pos)]) begin
        grant_o = 1'b1;
        idx_o   = IdxWidth'(pos);
      end
    end
  end

endmodule

// File: rtl/lock_cmd_arbiter.sv
// Round-robin arbiter funnelling accelerator lock commands into one registered output slot.
// Define LOCK_ARB_FILTER_EN to consume, but not forward, words that are neither LOCK nor UNLOCK.
module lock_cmd_arbiter
  import lock_cmd_arbiter_pkg::*;
#(
  parameter int unsigned MAX_ACCS = 16
) (
  input logic               clk,
  input logic               rstn,
  lock_cmd_arbiter_if.slave bus
);

  localparam int unsigned TidWidth = $clog2(MAX_ACCS);

  slot_state_e         state_q, state_d;
  logic [TidWidth-1:0] rr_ptr_q, rr_ptr_d;
  logic [TidWidth-1:0] tid_q, tid_d;
  logic [CmdWidth-1:0] data_q, data_d;

  logic                sel_grant;
  logic [TidWidth-1:0] sel_idx;
  logic [CmdWidth-1:0] sel_word;
  logic                can_arb;
  logic                grant;
  logic                load;

  lock_arb_rr_select #(
    .MAX_ACCS (MAX_ACCS)
  ) u_rr_select (
    .valid_i  (bus.in_TVALID),
    .rr_ptr_i (rr_ptr_q),
    .grant_o  (sel_grant),
    .idx_o    (sel_idx)
  );

  assign sel_word = bus.in_TDATA[CmdWidth*32'(sel_idx) +: CmdWidth];

  always_comb begin
    can_arb = (state_q == StEmpty) || bus.outStream_TREADY;
    // rstn gating keeps every in_TREADY low for as long as reset is asserted.
    grant   = sel_grant && can_arb && rstn;
`ifdef LOCK_ARB_FILTER_EN
    load    = grant && is_lock_cmd(sel_word);
`else
    load    = grant;
`endif

    state_d  = state_q;
    data_d   = data_q;
    tid_d    = tid_q;
    rr_ptr_d = rr_ptr_q;

    if (load) begin
      state_d = StFull;
      data_d  = sel_word;
      tid_d   = sel_idx;
    end else if ((state_q == StFull) && bus.outStream_TREADY) begin
      state_d = StEmpty;
    end

    if (grant) begin
      rr_ptr_d = (sel_idx == TidWidth'(MAX_ACCS - 1)) ? '0 : sel_idx + 1'b1;
    end

    bus.in_TREADY = '0;
    if (grant) begin
      bus.in_TREADY[sel_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StEmpty;
      rr_ptr_q <= '0;
      tid_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      tid_q    <= tid_d;
      data_q   <= data_d;
    end
  end

  assign bus.outStream_TVALID = (state_q == StFull);
  assign bus.outStream_TDATA  = data_q;
  assign bus.outStream_TID    = tid_q;

endmodule

// File: tb/tb_lock_cmd_arbiter.sv
// Bench for lock_cmd_arbiter: directed scenarios then random traffic, scored against a
// queue-based reference model; honours LOCK_ARB_FILTER_EN like the design.
module tb_lock_cmd_arbiter;

  import OmpSsManager::*;

  localparam int unsigned N = 16;
  localparam int unsigned W = $clog2(N);
`ifdef LOCK_ARB_FILTER_EN
  localparam bit Filt = 1'b1;
`else
  localparam bit Filt = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] tid;
    logic [63:0]  data;
  } item_t;

  logic  clk  = 1'b0;
  logic  rstn = 1'b0;
  int    errors = 0;
  int    checks = 0;
  item_t exp_q[$];
  int    m_ptr = 0;

  always #5 clk = ~clk;

  lock_cmd_arbiter_if #(.MAX_ACCS(N)) bus ();

  lock_cmd_arbiter #(
    .MAX_ACCS (N)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit forwarded(input logic [63:0] w);
    logic [7:0] c;
    c = w[CMD_TYPE_H:CMD_TYPE_L];
    return !Filt || (c == CMD_LOCK_CODE) || (c == CMD_UNLOCK_CODE);
  endfunction

  function automatic logic [63:0] mk(input logic [7:0] code, input logic [31:0] id);
    logic [63:0] w;
    w = {$urandom, $urandom};
    w[63:32] = id;
    w[CMD_TYPE_H:CMD_TYPE_L] = code;
    return w;
  endfunction

  function automatic logic [63:0] rand_word();
    int unsigned r;
    r = $urandom_range(0, 3);
    if (r < 2) return mk(CMD_LOCK_CODE, $urandom);
    if (r == 2) return mk(CMD_UNLOCK_CODE, $urandom);
    return mk(8'h10 | 8'($urandom_range(0, 15)), $urandom);
  endfunction

  // Monitor + reference model: one in-order queue of words owed to the lock unit.
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    logic [63:0]  w;
    int           gi;
    int           p;
    bit           busy;
    if (!rstn) begin
      exp_q.delete();
      m_ptr = 0;
      chk("rst_out_valid", 64'(bus.outStream_TVALID), 64'd0);
      chk("rst_in_tready", 64'(bus.in_TREADY), 64'd0);
      chk("rst_out_data", bus.outStream_TDATA, 64'd0);
      chk("rst_out_tid", 64'(bus.outStream_TID), 64'd0);
    end else begin
      chk("out_valid", 64'(bus.outStream_TVALID), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("out_data", bus.outStream_TDATA, exp_q[0].data);
        chk("out_tid", 64'(bus.outStream_TID), 64'(exp_q[0].tid));
      end
      busy = (exp_q.size() != 0) && !bus.outStream_TREADY;
      if ((exp_q.size() != 0) && bus.outStream_TREADY) void'(exp_q.pop_front());
      exp_rdy = '0;
      gi = -1;
      if (!busy) begin
        for (int k = 0; k < N; k++) begin
          p = (m_ptr + k) % N;
          if (gi < 0 && bus.in_TVALID[p]) gi = p;
        end
      end
      if (gi >= 0) exp_rdy[gi] = 1'b1;
      chk("in_tready", 64'(bus.in_TREADY), 64'(exp_rdy));
      if (gi >= 0) begin
        w = bus.in_TDATA[64*gi +: 64];
        if (forwarded(w)) exp_q.push_back(item_t'{tid: W'(gi), data: w});
        m_ptr = (gi + 1) % N;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_TVALID = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step(2);
    rstn = 1'b1;
  endtask

  initial begin
    bus.in_TDATA         = '0;
    bus.in_TVALID        = N'($urandom);
    bus.outStream_TREADY = 1'b1;
    do_reset();
    idle();
    step();

    // Single port: port 3 sends LOCK id 5.
    bus.in_TDATA[64*3 +: 64] = mk(CMD_LOCK_CODE, 5);
    bus.in_TVALID[3] = 1'b1;
    step();
    idle();
    step(3);

    // All ports valid continuously, lock unit always ready.
    do_reset();
    for (int i = 0; i < N; i++) bus.in_TDATA[64*i +: 64] = mk(CMD_LOCK_CODE, i);
    bus.in_TVALID = '1;
    step(17);
    idle();
    step(2);

    // Backpressure: hold port 0's word for 5 cycles, then drain and refill from port 1.
    do_reset();
    bus.outStream_TREADY = 1'b0;
    bus.in_TDATA[0 +: 64] = mk(CMD_UNLOCK_CODE, 100);
    bus.in_TVALID[0] = 1'b1;
    step();
    bus.in_TVALID[0] = 1'b0;
    bus.in_TDATA[64 +: 64] = mk(CMD_LOCK_CODE, 101);
    bus.in_TVALID[1] = 1'b1;
    step(5);
    bus.outStream_TREADY = 1'b1;
    step();
    idle();
    step(2);

    // Wrap-around: grant 14 so rr_ptr is 15, then ports 2 and 15 compete.
    do_reset();
    bus.in_TDATA[64*14 +: 64] = mk(CMD_LOCK_CODE, 14);
    bus.in_TVALID[14] = 1'b1;
    step();
    idle();
    bus.in_TDATA[64*2 +: 64]  = mk(CMD_LOCK_CODE, 2);
    bus.in_TDATA[64*15 +: 64] = mk(CMD_UNLOCK_CODE, 15);
    bus.in_TVALID[2]  = 1'b1;
    bus.in_TVALID[15] = 1'b1;
    step(2);
    idle();
    step(2);

    // Non-lock code from port 4; afterwards ports 3 and 5 show where rr_ptr went.
    bus.in_TDATA[64*4 +: 64] = mk(8'h3C, 9);
    bus.in_TVALID[4] = 1'b1;
    step();
    idle();
    step();
    bus.in_TDATA[64*3 +: 64] = mk(CMD_LOCK_CODE, 3);
    bus.in_TDATA[64*5 +: 64] = mk(CMD_LOCK_CODE, 5);
    bus.in_TVALID[3] = 1'b1;
    bus.in_TVALID[5] = 1'b1;
    step(2);
    idle();
    step(2);

    // Reset while a word is held under backpressure.
    bus.outStream_TREADY = 1'b0;
    bus.in_TDATA[64*7 +: 64] = mk(CMD_LOCK_CODE, 7);
    bus.in_TVALID[7] = 1'b1;
    step();
    idle();
    step(2);
    bus.in_TVALID = N'($urandom) | N'(1);
    bus.outStream_TREADY = 1'b1;
    rstn = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus.outStream_TVALID), 64'd0);
    chk("async_rst_tready", 64'(bus.in_TREADY), 64'd0);
    step(2);
    rstn = 1'b1;
    idle();
    step(2);

    // Random traffic with random backpressure.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) bus.in_TDATA[64*i +: 64] = rand_word();
      bus.in_TVALID = N'($urandom) & N'($urandom);
      bus.outStream_TREADY = ($urandom_range(0, 3) != 0);
      step();
    end

    idle();
    bus.outStream_TREADY = 1'b1;
    step(3);
    chk("drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lock_cmd_arbiter.md
LOCK_CMD_ARBITER -- requirements
Module: lock_cmd_arbiter

Interface
REQ-001 SHALL have parameter MAX_ACCS, default 16: number of accelerator command ports; legal range 2..256.
REQ-002 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-003 SHALL have port rstn, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port in_TDATA, input, 64*MAX_ACCS: command word of port i at bits [64*i+63:64*i].
REQ-005 SHALL have port in_TVALID, input, MAX_ACCS: per-port command valid.
REQ-006 SHALL have port in_TREADY, output, MAX_ACCS: per-port accept; at most one bit high per cycle.
REQ-007 SHALL have port outStream_TDATA, output, 64: forwarded command word to the lock unit.
REQ-008 SHALL have port outStream_TVALID, output, 1: output word valid.
REQ-009 SHALL have port outStream_TREADY, input, 1: lock unit accepts.
REQ-010 SHALL have port outStream_TID, output, clog2(MAX_ACCS): index of the source port.

Function
REQ-011 SHALL hold one output register slot, in state EMPTY or FULL; outStream_TVALID = (state == FULL).
REQ-012 SHALL evaluate arbitration when slot EMPTY, or FULL with outStream_TREADY high (drain and refill in the same cycle).
REQ-013 SHALL grant the first asserted in_TVALID searching upward from rr_ptr, wrapping MAX_ACCS-1 -> 0.
REQ-014 SHALL assert in_TREADY[g] combinationally in the grant cycle only; the command is taken that cycle.
REQ-015 SHALL present the granted word on outStream_TDATA, with outStream_TID = g, from the next cycle (latency 1).
REQ-016 SHALL set rr_ptr to (g+1) mod MAX_ACCS after each grant; rr_ptr unchanged when no grant.
REQ-017 SHALL keep outStream_TDATA/TID/TVALID stable while FULL and outStream_TREADY low.
REQ-018 SHALL transition FULL -> EMPTY on outStream_TREADY with no grant, EMPTY -> FULL on grant, FULL -> FULL on drain plus grant.
REQ-019 SHALL sustain one command per cycle when the lock unit is always ready.
REQ-020 SHALL never assert any in_TREADY while FULL and outStream_TREADY low (backpressure to all ports).
REQ-021 SHALL serve every continuously-valid port within MAX_ACCS grants (no starvation).
REQ-022 SHALL keep in_TREADY independent of in_TDATA contents, except as stated in REQ-029.

Reset
REQ-023 SHALL, on rstn low, set state EMPTY, rr_ptr 0, outStream_TVALID 0 and all in_TREADY 0 immediately (asynchronously).
REQ-024 SHALL reset outStream_TDATA to 0 and outStream_TID to 0.
REQ-025 SHALL discard a held word on reset mid-transfer; no replay after reset release.
REQ-026 SHALL accept no command in the cycle rstn deasserts if rstn is sampled low at that edge.

Configuration
REQ-027 SHALL recognise macro LOCK_ARB_FILTER_EN.
REQ-028 SHALL, without LOCK_ARB_FILTER_EN, forward every granted word regardless of command code.
REQ-029 SHALL, with LOCK_ARB_FILTER_EN, grant and consume a word whose CMD_TYPE field is neither CMD_LOCK_CODE nor CMD_UNLOCK_CODE, but not load it into the slot.
REQ-030 SHALL, with LOCK_ARB_FILTER_EN, apply REQ-016 to dropped words and leave slot state unchanged by them, except for a same-cycle drain.

Structure
REQ-031 SHALL take CMD_TYPE_H, CMD_TYPE_L, CMD_LOCK_CODE and CMD_UNLOCK_CODE from the shared OmpSsManager package, with no local copies.
REQ-032 SHALL place the round-robin search in one combinational sub-module, lock_arb_rr_select: inputs valid vector and rr_ptr; outputs grant flag and index.

Verification
REQ-033 SHALL cover single port: port 3 sends LOCK id 5 with ready high -> in_TREADY[3] pulse, next cycle outStream_TVALID=1, TID=3, data unchanged.
REQ-034 SHALL cover all 16 ports valid continuously, ready high -> grants 0,1,...,15,0 in consecutive cycles, one word per cycle.
REQ-035 SHALL cover backpressure: port 0 word held, outStream_TREADY low 5 cycles -> output stable and all in_TREADY 0; on ready, drain and refill from port 1 in the same cycle.
REQ-036 SHALL cover wrap-around: rr_ptr=15 with ports 2 and 15 valid -> 15 granted, then 2.
REQ-037 SHALL cover filtering with LOCK_ARB_FILTER_EN: port 4 sends a non-lock code -> in_TREADY[4] pulses, outStream_TVALID stays 0, rr_ptr becomes 5; without the macro the word is forwarded with TID=4.
REQ-038 SHALL cover reset mid-hold: FULL with ready low, rstn low -> outStream_TVALID 0 at once; after release, state is EMPTY and rr_ptr 0.
